camera_capture_pack: RTL and testbench

Parametrised successor to the fixed 64-bit camera byte packer. Samples the camera byte stream on camera_pclk and packs DATA_W-bit samples MSB-first into OUT_W-bit words for the DDR write path. Adds:
- frame-aligned start, waiting for a full vsync cycle
- zero-padded flush of a partial word at end of line
- start-of-frame and end-of-line markers
- line/frame length checking and counters

Sits between the camera pins and the DDR write FIFO, entirely in the camera_pclk domain.

---
 rtl/camera_capture_pkg.sv | 41 ++++
 rtl/cam_byte_packer.sv | 91 +++++++++
 rtl/camera_capture_pack.sv | 178 +++++++++++++++++
 tb/tb_camera_capture_pack.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_capture_pkg.sv
// rtl/camera_capture_pkg.sv - shared types and width helpers for the camera capture packer
package camera_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC_HI = 2'd1,
        S_SYNC_LO = 2'd2,
        S_CAPTURE = 2'd3
    } cap_state_e;

    // Per-line sample counter width; the counter saturates rather than wraps.
    localparam int SCNT_W = 16;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Samples per packed output word.
    function automatic int pack_ratio(input int out_w, input int data_w);
        return out_w / data_w;
    endfunction

    // Pack-count width; the count must reach R itself to mark a full word.
    function automatic int pcnt_width(input int r);
        return clog2(r + 1);
    endfunction

    // Zero bits appended below a partial word holding cnt samples.
    function automatic int pad_bits(input int r, input int cnt, input int data_w);
        return data_w * (r - cnt);
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// rtl/cam_byte_packer.sv - MSB-first sample shifter with a one-word output holding stage
module cam_byte_packer
    import camera_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              flush,
    input  logic              sof_in,
    input  logic [DATA_W-1:0] din,
    output logic [OUT_W-1:0]  word,
    output logic              valid,
    output logic              sof,
    output logic              eol
);

    localparam int R  = pack_ratio(OUT_W, DATA_W);
    localparam int CW = pcnt_width(R);
    localparam logic [CW-1:0] CNT_FULL = CW'(R);

    logic [OUT_W-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;

    // A full word is held until the next push or a flush, so the end-of-line
    // flag can ride on the same strobe as the line's final full word.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        if (clr) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (push) begin
            if (cnt_q == CNT_FULL) begin
                word_d  = sr_q;
                valid_d = 1'b1;
                sof_d   = sof_in;
                sr_d    = OUT_W'(din);
                cnt_d   = CW'(1);
            end else begin
                sr_d  = {sr_q[OUT_W-DATA_W-1:0], din};
                cnt_d = cnt_q + CW'(1);
            end
        end else if (flush) begin
            if (cnt_q != '0) begin
                word_d  = sr_q << pad_bits(R, int'(cnt_q), DATA_W);
                valid_d = 1'b1;
                sof_d   = sof_in;
                eol_d   = 1'b1;
            end
            sr_d  = '0;
            cnt_d = '0;
        end
    end

    // Packer state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign word  = word_q;
    assign valid = valid_q;
    assign sof   = sof_q;
    assign eol   = eol_q;

endmodule

// File: rtl/camera_capture_pack.sv
// rtl/camera_capture_pack.sv - frame-aligned camera sample capture and word packing
module camera_capture_pack
    import camera_capture_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 64,
    parameter int H_BYTES = 2560,
    parameter int V_LINES = 720,
    parameter int FCNT_W  = 16
) (
    input  logic                          camera_pclk,
    input  logic                          rst,
    input  logic                          init_done,
    input  logic                          frame_en,
    input  logic                          camera_href,
    input  logic                          camera_vsync,
    input  logic [DATA_W-1:0]             camera_data,
    output logic                          wr_en,
    output logic [OUT_W-1:0]              wr_data,
    output logic                          wr_sof,
    output logic                          wr_eol,
    output logic                          frame_done,
    output logic                          err_line,
    output logic                          err_frame,
    output logic [clog2(V_LINES+1):0]     line_cnt,
    output logic [FCNT_W-1:0]             frame_cnt
);

    localparam int LCW = clog2(V_LINES + 1) + 1;
    localparam logic [LCW-1:0]    LCNT_MAX = '1;
    localparam logic [LCW-1:0]    V_EXP    = LCW'(V_LINES);
    localparam logic [SCNT_W-1:0] SCNT_MAX = '1;
    localparam logic [SCNT_W-1:0] H_EXP    = SCNT_W'(H_BYTES);

    cap_state_e        state_q, state_d;
    logic              href_q, href_d;
    logic              vsync_q, vsync_d;
    logic              sof_pend_q, sof_pend_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [LCW-1:0]    line_cnt_q, line_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              err_line_q, err_line_d;
    logic              err_frame_q, err_frame_d;

    logic              in_cap, accept, fall, vs_rise, pk_clr, pk_sof;
    logic [LCW-1:0]    lines_done;
    logic              pk_valid;

    // Frame sync FSM, line/frame bookkeeping and packer control.
    always_comb begin
        state_d      = state_q;
        href_d       = camera_href;
        vsync_d      = camera_vsync;
        sof_pend_d   = sof_pend_q;
        scnt_d       = scnt_q;
        line_cnt_d   = line_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        err_line_d   = 1'b0;
        err_frame_d  = 1'b0;

        in_cap  = (state_q == S_CAPTURE) && init_done;
        accept  = in_cap && camera_href && !camera_vsync;
        fall    = in_cap && href_q && !camera_href;
        vs_rise = in_cap && camera_vsync && !vsync_q;
        pk_clr  = !in_cap;
        // A strobe already in flight carried the frame's first word.
        pk_sof  = sof_pend_q && !pk_valid;

        if (pk_valid) begin
            sof_pend_d = 1'b0;
        end

        if (accept && (scnt_q != SCNT_MAX)) begin
            scnt_d = scnt_q + SCNT_W'(1);
        end

        lines_done = line_cnt_q;
        if (fall) begin
            err_line_d = (scnt_q != H_EXP);
            scnt_d     = '0;
            if (line_cnt_q != LCNT_MAX) begin
                lines_done = line_cnt_q + LCW'(1);
            end
            line_cnt_d = lines_done;
        end

        if (!in_cap) begin
            scnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (init_done && frame_en) begin
                    state_d = S_SYNC_HI;
                end
            end
            S_SYNC_HI: begin
                if (camera_vsync) begin
                    state_d = S_SYNC_LO;
                end
            end
            S_SYNC_LO: begin
                if (!camera_vsync && init_done) begin
                    state_d    = S_CAPTURE;
                    line_cnt_d = '0;
                    sof_pend_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    err_frame_d  = (lines_done != V_EXP);
                    frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                    state_d      = frame_en ? S_SYNC_LO : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!init_done) begin
            state_d = S_IDLE;
        end
    end

    // Control and status registers.
    always_ff @(posedge camera_pclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            sof_pend_q   <= 1'b0;
            scnt_q       <= '0;
            line_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            href_q       <= href_d;
            vsync_q      <= vsync_d;
            sof_pend_q   <= sof_pend_d;
            scnt_q       <= scnt_d;
            line_cnt_q   <= line_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            err_line_q   <= err_line_d;
            err_frame_q  <= err_frame_d;
        end
    end

    cam_byte_packer #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_packer (
        .clk    (camera_pclk),
        .rst    (rst),
        .clr    (pk_clr),
        .push   (accept),
        .flush  (fall),
        .sof_in (pk_sof),
        .din    (camera_data),
        .word   (wr_data),
        .valid  (pk_valid),
        .sof    (wr_sof),
        .eol    (wr_eol)
    );

    assign wr_en      = pk_valid;
    assign frame_done = frame_done_q;
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;
    assign line_cnt   = line_cnt_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_camera_capture_pack.sv
// tb/tb_camera_capture_pack.sv - randomized scoreboard bench for camera_capture_pack
module tb_camera_capture_pack;

    localparam int DATA_W  = 8;
    localparam int OUT_W   = 64;
    localparam int H_BYTES = 16;
    localparam int V_LINES = 2;
    localparam int FCNT_W  = 16;
    localparam int R       = OUT_W / DATA_W;
    localparam int LCW     = $clog2(V_LINES + 1) + 1;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             err;
    } word_t;
    typedef struct {
        logic err;
        int   lines;
        int   fcnt;
    } frm_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic              frame_en;
    logic              href;
    logic              vsync;
    logic [DATA_W-1:0] data;
    logic              wr_en;
    logic [OUT_W-1:0]  wr_data;
    logic              wr_sof;
    logic              wr_eol;
    logic              frame_done;
    logic              err_line;
    logic              err_frame;
    logic [LCW-1:0]    line_cnt;
    logic [FCNT_W-1:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    word_t            exp_q[$];
    frm_t             frm_q[$];
    word_t            mon_w;
    frm_t             mon_f;
    logic [OUT_W-1:0] last_word = '0;

    bit capturing = 0;
    bit seen_high = 0;
    bit sof_pend_m = 0;
    int lines_m = 0;
    int fcnt_m = 0;

    camera_capture_pack #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .H_BYTES (H_BYTES),
        .V_LINES (V_LINES),
        .FCNT_W  (FCNT_W)
    ) dut (
        .camera_pclk  (clk),
        .rst          (rst),
        .init_done    (init_done),
        .frame_en     (frame_en),
        .camera_href  (href),
        .camera_vsync (vsync),
        .camera_data  (data),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_sof       (wr_sof),
        .wr_eol       (wr_eol),
        .frame_done   (frame_done),
        .err_line     (err_line),
        .err_frame    (err_frame),
        .line_cnt     (line_cnt),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t ramp(input logic [7:0] start, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(start + i));
        return q;
    endfunction

    function automatic bq_t rand_line();
        bq_t q;
        int  n;
        n = ($urandom_range(0, 1) == 1) ? H_BYTES : int'($urandom_range(1, 24));
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: split the line into R-sample groups, first sample in the top
    // bits, last group zero-padded; eol and the length error go on the last word.
    task automatic model_line(input bq_t b);
        int n;
        int nw;
        n  = b.size();
        nw = (n + R - 1) / R;
        for (int w = 0; w < nw; w++) begin
            word_t e;
            e.data = '0;
            for (int k = 0; k < R; k++) begin
                if (w * R + k < n) e.data[OUT_W-1-DATA_W*k -: DATA_W] = b[w*R+k];
            end
            e.sof      = sof_pend_m;
            sof_pend_m = 0;
            e.eol      = (w == nw - 1);
            e.err      = (w == nw - 1) && (n != H_BYTES);
            exp_q.push_back(e);
        end
        lines_m++;
    endtask

    task automatic send_line(input bq_t b);
        if (capturing) model_line(b);
        foreach (b[i]) begin
            href = 1'b1;
            data = b[i];
            tick();
        end
        href = 1'b0;
        data = 8'($urandom);
        repeat (2 + $urandom_range(0, 3)) tick();
    endtask

    task automatic frame_start();
        if (capturing) begin
            frm_t f;
            f.err  = (lines_m != V_LINES);
            f.lines = lines_m;
            fcnt_m = (fcnt_m + 1) % (1 << FCNT_W);
            f.fcnt = fcnt_m;
            frm_q.push_back(f);
        end
        capturing = 0;
        seen_high = init_done && frame_en;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        if (seen_high) begin
            capturing  = 1;
            lines_m    = 0;
            sof_pend_m = 1;
        end
        repeat (2) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_sof"}, wr_sof, 0);
        check({tag, "_wr_eol"}, wr_eol, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_err_line"}, err_line, 0);
        check({tag, "_err_frame"}, err_frame, 0);
        check({tag, "_line_cnt"}, line_cnt, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Scoreboard: every strobe and every frame_done is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_en", 1, 0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("wr_data", wr_data, mon_w.data);
                    check("wr_sof", wr_sof, mon_w.sof);
                    check("wr_eol", wr_eol, mon_w.eol);
                    check("err_line", err_line, mon_w.err);
                    last_word = mon_w.data;
                end
            end else if (err_line) begin
                check("err_line_stray", 1, 0);
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    mon_f = frm_q.pop_front();
                    check("err_frame", err_frame, mon_f.err);
                    check("line_cnt", line_cnt, mon_f.lines);
                    check("frame_cnt", frame_cnt, mon_f.fcnt);
                end
            end else if (err_frame) begin
                check("err_frame_stray", 1, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; init_done = 1'b0; frame_en = 1'b0;
        href = 1'b0; vsync = 1'b0; data = '0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // Enabled mid-frame: nothing captured until a full vsync cycle.
        init_done = 1'b1; frame_en = 1'b1;
        repeat (2) tick();
        send_line(ramp(8'h30, 16));
        send_line(ramp(8'h40, 16));

        // Two exact lines.
        frame_start();
        send_line(ramp(8'h00, 16));
        send_line(ramp(8'h00, 16));

        // Short line with padded flush and line error.
        frame_start();
        send_line(ramp(8'hA0, 13));
        send_line(ramp(8'h50, 16));

        // Too many lines.
        frame_start();
        repeat (3) send_line(ramp(8'h10, 16));

        // Random frames.
        repeat (6) begin
            frame_start();
            repeat ($urandom_range(1, 3)) send_line(rand_line());
        end

        // init_done dropped mid-line; re-raising needs a new vsync cycle.
        frame_start();
        for (int i = 0; i < 5; i++) begin
            href = 1'b1;
            data = 8'(8'hC0 + i);
            tick();
        end
        href = 1'b0; init_done = 1'b0;
        capturing = 0; seen_high = 0;
        repeat (3) tick();
        init_done = 1'b1;
        repeat (2) tick();
        send_line(ramp(8'h60, 16));
        frame_start();
        send_line(ramp(8'h70, 16));
        send_line(ramp(8'h80, 11));

        // Reset mid-line, then a clean frame.
        frame_start();
        for (int i = 0; i < 5; i++) begin
            href = 1'b1;
            data = 8'(8'hE0 + i);
            tick();
        end
        rst = 1'b1; href = 1'b0;
        tick();
        check_zero_outputs("midreset");
        capturing = 0; seen_high = 0; fcnt_m = 0;
        last_word = '0;
        rst = 1'b0;
        tick();
        frame_start();
        send_line(ramp(8'h00, 16));
        send_line(rand_line());

        // Close the last frame with capture disabled.
        frame_en = 1'b0;
        frame_start();
        send_line(ramp(8'h90, 16));
        repeat (10) tick();

        check("words_left", exp_q.size(), 0);
        check("frames_left", frm_q.size(), 0);
        check("final_frame_cnt", frame_cnt, fcnt_m);
        check("wr_data_hold", wr_data, last_word);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
